// File: rtl/param_frame_pkg.sv
// -----------------------------------------------------------------------------
// param_frame_pkg
// Shared types and helpers for the parameter frame loader.
//   pfl_state_e : loader FSM states (CHK only reachable with PFL_CHECKSUM_EN)
//   nbytes()    : payload bytes per frame for a given word width / word count
//   CNT_W       : byte-counter width for the default 2x32 configuration
// -----------------------------------------------------------------------------
package param_frame_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CHK  = 2'd2,
      WAIT = 2'd3
   } pfl_state_e;

   function automatic int nbytes(input int word_w, input int num_words);
      return (num_words * word_w) / 8;
   endfunction

   localparam int DEF_WORD_W    = 32;
   localparam int DEF_NUM_WORDS = 2;
   localparam int DEF_NB        = nbytes(DEF_WORD_W, DEF_NUM_WORDS);
   // Counter must also hold NB while a checksum byte is pending.
   localparam int CNT_W         = $clog2(DEF_NB + 2);

endpackage : param_frame_pkg

// File: rtl/pin_sync_edge.sv
// -----------------------------------------------------------------------------
// pin_sync_edge
// Brings a group of asynchronous pins into the clk domain through SYNC_STAGES
// flops and flags the rising edge of the group's top bit (the qualifier pin).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d   [W]    : raw asynchronous pins; d[W-1] is the edge-detected pin
//   q   [W]    : synchronised, registered level of d
//   rise       : one-cycle pulse when q[W-1] goes 0 -> 1
// -----------------------------------------------------------------------------
module pin_sync_edge #(
   parameter int W           = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         rise
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q;
   logic                          hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the whole chain is reset (it is a handful of flops, not a RAM)
         // so the edge history starts low and no phantom edge follows reset.
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the previous
         // stage's old value, which is what forms the shift chain.
         sync_q[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         hist_q <= sync_q[SYNC_STAGES-1][W-1];
      end
   end

   assign q    = sync_q[SYNC_STAGES-1];
   assign rise = q[W-1] & ~hist_q;

endmodule : pin_sync_edge

// File: rtl/param_frame_loader.sv
// -----------------------------------------------------------------------------
// param_frame_loader
// Assembles NUM_WORDS signed WORD_W-bit parameter words from a byte-wide,
// asynchronously strobed pin stream and commits the frame to eig_core with a
// one-cycle start pulse once the core is idle.
// Optional feature macro: PFL_CHECKSUM_EN (one checksum byte per frame, frame
// accepted only if payload + checksum sums to 0 mod 256; otherwise err_o).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : block enable; low freezes the FSM and drops pin edges
//   data_in    : byte pins (async)
//   strobe_in  : byte strobe pin (async), rising edge = byte valid
//   fsync_in   : frame-sync pin (async), rising edge = abort / restart frame
//   core_busy  : downstream busy, blocks the commit while high
//   words_o    : committed words, word k at [k*WORD_W +: WORD_W]
//   start_o    : one-cycle pulse, aligned with the cycle words_o is updated
//   loading_o  : high while a frame is partially received
//   err_o      : sticky checksum error, cleared by the next frame's first byte
// -----------------------------------------------------------------------------
module param_frame_loader
   import param_frame_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int NUM_WORDS   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [7:0]                    data_in,
   input  logic                          strobe_in,
   input  logic                          fsync_in,
   input  logic                          core_busy,
   output logic [NUM_WORDS*WORD_W-1:0]   words_o,
   output logic                          start_o,
   output logic                          loading_o,
   output logic                          err_o
);

   localparam int NB    = nbytes(WORD_W, NUM_WORDS);
   localparam int CW    = $clog2(NB + 2);
   localparam int TOT_W = NUM_WORDS * WORD_W;

   // State entered after the last payload byte.
`ifdef PFL_CHECKSUM_EN
   localparam pfl_state_e FULL_ST = CHK;
`else
   localparam pfl_state_e FULL_ST = WAIT;
`endif

   // --------------------------------------------------------------------------
   // Pin synchronisers. Strobe and data travel together so the captured byte
   // is the one that was on the pins when the strobe rose.
   // --------------------------------------------------------------------------
   logic [7:0] byte_data;
   logic       strobe_lvl_unused;
   logic       byte_rise;
   logic       fsync_lvl_unused;
   logic       fsync_rise;

   pin_sync_edge #(.W(9), .SYNC_STAGES(SYNC_STAGES)) u_byte_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({strobe_in, data_in}),
      .q     ({strobe_lvl_unused, byte_data}),
      .rise  (byte_rise)
   );

   pin_sync_edge #(.W(1), .SYNC_STAGES(SYNC_STAGES)) u_fsync_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fsync_in),
      .q     (fsync_lvl_unused),
      .rise  (fsync_rise)
   );

   // Edges arriving while disabled are simply lost; the synchroniser history
   // keeps running so re-enabling never manufactures an edge.
   logic byte_ev;
   logic fsync_ev;

   assign byte_ev  = byte_rise  & ena;
   assign fsync_ev = fsync_rise & ena;

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   pfl_state_e state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [TOT_W-1:0] shadow_q;
   logic [TOT_W-1:0] shadow_words;
   logic [TOT_W-1:0] words_q;
   logic             start_q;

   logic capture;
   logic discard;
   logic commit;
   logic last_byte;

   assign last_byte = (cnt_q == CW'(NB - 1));

`ifdef PFL_CHECKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] sum_chk;
   logic       err_q;
   logic       err_set;
   logic       err_clr;

   assign sum_chk = sum_q + byte_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d = state_q;
      capture = 1'b0;
      discard = 1'b0;
      commit  = 1'b0;
`ifdef PFL_CHECKSUM_EN
      err_set = 1'b0;
      err_clr = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // fsync wins over a simultaneous byte edge.
            if (fsync_ev) begin
               discard = 1'b1;
            end else if (byte_ev) begin
               capture = 1'b1;
`ifdef PFL_CHECKSUM_EN
               err_clr = 1'b1;
`endif
               state_d = last_byte ? FULL_ST : LOAD;
            end
         end
         LOAD: begin
            if (fsync_ev) begin
               discard = 1'b1;
               state_d = IDLE;
            end else if (byte_ev) begin
               capture = 1'b1;
               if (last_byte) begin
                  state_d = FULL_ST;
               end
            end
         end
`ifdef PFL_CHECKSUM_EN
         CHK: begin
            if (fsync_ev) begin
               discard = 1'b1;
               state_d = IDLE;
            end else if (byte_ev) begin
               if (sum_chk == 8'h00) begin
                  state_d = WAIT;
               end else begin
                  err_set = 1'b1;
                  discard = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`endif
         WAIT: begin
            // Byte and fsync edges are ignored here; only the commit matters.
            if (ena && !core_busy) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath. Bytes shift in MSB-first, so the first received word ends up in
   // the top of shadow_q; the word order is reversed on the way to words_o.
   // --------------------------------------------------------------------------
   always_comb begin
      shadow_words = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         shadow_words[k*WORD_W +: WORD_W] = shadow_q[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         words_q  <= '0;
         start_q  <= 1'b0;
      end else begin
         start_q <= commit;
         if (discard || commit) begin
            cnt_q    <= '0;
            shadow_q <= '0;
         end else if (capture) begin
            cnt_q    <= cnt_q + CW'(1);
            shadow_q <= (shadow_q << 8) | TOT_W'(byte_data);
         end
         if (commit) begin
            words_q <= shadow_words;
         end
      end
   end

`ifdef PFL_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= 8'h00;
         err_q <= 1'b0;
      end else begin
         if (discard || commit) begin
            sum_q <= 8'h00;
         end else if (capture) begin
            sum_q <= sum_chk;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign words_o   = words_q;
   assign start_o   = start_q;
   assign loading_o = (state_q == LOAD);

endmodule : param_frame_loader
